// File: rtl/alu_multicycle_if.sv
// Command/result handshake bundle for alu_multicycle; the ALU sits on the slave modport.
interface alu_multicycle_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             carry;
    logic             err;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, result_hi, carry, err
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, result_hi, carry, err
    );
endinterface

// File: rtl/alu_multicycle.sv
// Handshaked ALU: one-cycle logic/arithmetic ops, iterative shift-add MUL and restoring DIV.
// Define ALU_MULDIV_EN to build the MUL/DIV datapath; otherwise ops 2/3 complete at once with err=1.
module alu_multicycle #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    alu_multicycle_if.slave bus
);

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR,  OP_XOR, OP_NAND,
        OP_NOR, OP_XNOR, OP_SHL, OP_SHR, OP_GT, OP_LT, OP_EQ, OP_INC
    } op_e;

`ifdef ALU_MULDIV_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;
`else
    typedef enum logic [0:0] {S_IDLE, S_DONE} state_e;
`endif

    localparam logic [WIDTH:0] SHIFT_LIMIT = (WIDTH + 1)'(WIDTH);

    if (WIDTH < 2 || WIDTH > 16 || CNT_W < $clog2(WIDTH)) begin : g_bad_params
        $error("alu_multicycle: illegal WIDTH/CNT_W combination");
    end

    state_e           state_q,     state_d;
    logic [WIDTH-1:0] result_q,    result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             carry_q,     carry_d;
    logic             err_q,       err_d;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   inc_sum;

`ifdef ALU_MULDIV_EN
    logic [CNT_W-1:0]   cnt_q,  cnt_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand (MUL) or divisor (DIV)
    logic [2*WIDTH-1:0] acc_q,  acc_d;    // {partial hi, multiplier} or {remainder, dividend/quotient}
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
`endif

    assign add_sum = {1'b0, bus.a} + {1'b0, bus.b};
    assign inc_sum = {1'b0, bus.a} + (WIDTH + 1)'(1);

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        carry_d     = carry_q;
        err_d       = err_q;
`ifdef ALU_MULDIV_EN
        cnt_d       = cnt_q;
        opnd_d      = opnd_q;
        acc_d       = acc_q;
        mul_sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift   = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff    = div_shift - {1'b0, opnd_q};
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    state_d     = S_DONE;
                    result_d    = '0;
                    result_hi_d = '0;
                    carry_d     = 1'b0;
                    err_d       = 1'b0;
                    case (op_e'(bus.op))
                        OP_ADD:  {carry_d, result_d} = add_sum;
                        OP_SUB: begin
                            result_d = bus.a - bus.b;
                            carry_d  = bus.a < bus.b;
                        end
`ifdef ALU_MULDIV_EN
                        OP_MUL: begin
                            state_d = S_MUL;
                            opnd_d  = bus.a;
                            acc_d   = {{WIDTH{1'b0}}, bus.b};
                            cnt_d   = '0;
                        end
                        OP_DIV: begin
                            if (bus.b == '0) begin
                                result_d    = '1;
                                result_hi_d = bus.a;
                                err_d       = 1'b1;
                            end else begin
                                state_d = S_DIV;
                                opnd_d  = bus.b;
                                acc_d   = {{WIDTH{1'b0}}, bus.a};
                                cnt_d   = '0;
                            end
                        end
`else
                        OP_MUL, OP_DIV: err_d = 1'b1;
`endif
                        OP_AND:  result_d = bus.a & bus.b;
                        OP_OR:   result_d = bus.a | bus.b;
                        OP_XOR:  result_d = bus.a ^ bus.b;
                        OP_NAND: result_d = ~(bus.a & bus.b);
                        OP_NOR:  result_d = ~(bus.a | bus.b);
                        OP_XNOR: result_d = ~(bus.a ^ bus.b);
                        OP_SHL:  result_d = ({1'b0, bus.b} >= SHIFT_LIMIT) ? '0 : bus.a << bus.b;
                        OP_SHR:  result_d = ({1'b0, bus.b} >= SHIFT_LIMIT) ? '0 : bus.a >> bus.b;
                        OP_GT:   result_d = WIDTH'(bus.a > bus.b);
                        OP_LT:   result_d = WIDTH'(bus.a < bus.b);
                        OP_EQ:   result_d = WIDTH'(bus.a == bus.b);
                        OP_INC:  {carry_d, result_d} = inc_sum;
                        default: ;
                    endcase
                end
            end
`ifdef ALU_MULDIV_EN
            S_MUL: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d     = S_DONE;
                    result_d    = acc_d[WIDTH-1:0];
                    result_hi_d = acc_d[2*WIDTH-1:WIDTH];
                end
            end
            S_DIV: begin
                // A negative trial difference means the shifted remainder is restored unchanged.
                if (div_diff[WIDTH]) begin
                    acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d     = S_DONE;
                    result_d    = acc_d[WIDTH-1:0];
                    result_hi_d = acc_d[2*WIDTH-1:WIDTH];
                end
            end
`endif
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            result_q    <= '0;
            result_hi_q <= '0;
            carry_q     <= 1'b0;
            err_q       <= 1'b0;
`ifdef ALU_MULDIV_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            carry_q     <= carry_d;
            err_q       <= err_d;
`ifdef ALU_MULDIV_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

`ifdef ALU_MULDIV_EN
    // NOTE: operand/accumulator flops are not reset; they are always loaded on accept before use.
    always_ff @(posedge clk) begin
        opnd_q <= opnd_d;
        acc_q  <= acc_d;
    end
`endif

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
    assign bus.carry     = carry_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed + random bench for alu_multicycle at WIDTH=4 and WIDTH=8, scoreboard-checked.
module tb_alu_multicycle;

    localparam int W_N     = 4;
    localparam int W_W     = 8;
    localparam int TIMEOUT = 40;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR,  OP_XOR, OP_NAND,
        OP_NOR, OP_XNOR, OP_SHL, OP_SHR, OP_GT, OP_LT, OP_EQ, OP_INC
    } op_e;

    typedef struct {
        string       tag;
        int unsigned res;
        int unsigned hi;
        int unsigned carry;
        int unsigned err;
        int unsigned lat;
    } exp_t;

    typedef struct {
        logic [31:0] valid;
        logic [31:0] ready;
        logic [31:0] res;
        logic [31:0] hi;
        logic [31:0] carry;
        logic [31:0] err;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    alu_multicycle_if #(.WIDTH(W_N)) bus4 ();
    alu_multicycle_if #(.WIDTH(W_W)) bus8 ();

    alu_multicycle #(.WIDTH(W_N)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
    alu_multicycle #(.WIDTH(W_W)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model built from native arithmetic, independent of the iterative datapath.
    function automatic exp_t model(input int w, input op_e op, input int unsigned a,
                                   input int unsigned b, input string tag);
        exp_t        e;
        int unsigned mask = (32'd1 << w) - 32'd1;
        int unsigned p;
        e.tag = tag; e.res = 0; e.hi = 0; e.carry = 0; e.err = 0; e.lat = 1;
        case (op)
            OP_ADD:  begin p = a + b; e.res = p & mask; e.carry = 32'(p[w]); end
            OP_SUB:  begin e.res = (a - b) & mask; e.carry = (a < b) ? 1 : 0; end
`ifdef ALU_MULDIV_EN
            OP_MUL:  begin p = a * b; e.res = p & mask; e.hi = (p >> w) & mask; e.lat = w + 1; end
            OP_DIV: begin
                if (b == 0) begin
                    e.res = mask; e.hi = a; e.err = 1;
                end else begin
                    e.res = a / b; e.hi = a % b; e.lat = w + 1;
                end
            end
`else
            OP_MUL, OP_DIV: e.err = 1;
`endif
            OP_AND:  e.res = a & b;
            OP_OR:   e.res = a | b;
            OP_XOR:  e.res = a ^ b;
            OP_NAND: e.res = ~(a & b) & mask;
            OP_NOR:  e.res = ~(a | b) & mask;
            OP_XNOR: e.res = ~(a ^ b) & mask;
            OP_SHL:  e.res = (b >= w) ? 0 : (a << b) & mask;
            OP_SHR:  e.res = (b >= w) ? 0 : a >> b;
            OP_GT:   e.res = (a > b) ? 1 : 0;
            OP_LT:   e.res = (a < b) ? 1 : 0;
            OP_EQ:   e.res = (a == b) ? 1 : 0;
            OP_INC:  begin p = a + 1; e.res = p & mask; e.carry = 32'(p[w]); end
            default: ;
        endcase
        return e;
    endfunction

    function automatic obs_t sample(input bit wide);
        obs_t o;
        if (wide) begin
            o.valid = 32'(bus8.out_valid); o.ready = 32'(bus8.in_ready);
            o.res   = 32'(bus8.result);    o.hi    = 32'(bus8.result_hi);
            o.carry = 32'(bus8.carry);     o.err   = 32'(bus8.err);
        end else begin
            o.valid = 32'(bus4.out_valid); o.ready = 32'(bus4.in_ready);
            o.res   = 32'(bus4.result);    o.hi    = 32'(bus4.result_hi);
            o.carry = 32'(bus4.carry);     o.err   = 32'(bus4.err);
        end
        return o;
    endfunction

    task automatic drive(input bit wide, input logic v, input op_e op,
                         input int unsigned a, input int unsigned b);
        if (wide) begin
            bus8.in_valid = v; bus8.op = op; bus8.a = W_W'(a); bus8.b = W_W'(b);
        end else begin
            bus4.in_valid = v; bus4.op = op; bus4.a = W_N'(a); bus4.b = W_N'(b);
        end
    endtask

    task automatic set_out_ready(input bit wide, input logic v);
        if (wide) bus8.out_ready = v;
        else      bus4.out_ready = v;
    endtask

    task automatic check_idle_reset(input bit wide, input string tag);
        obs_t o = sample(wide);
        check({tag, "_valid"}, o.valid, 0);
        check({tag, "_ready"}, o.ready, 1);
        check({tag, "_res"},   o.res,   0);
        check({tag, "_hi"},    o.hi,    0);
        check({tag, "_carry"}, o.carry, 0);
        check({tag, "_err"},   o.err,   0);
    endtask

    // Starts and ends at a negedge. While busy, in_valid is held high with junk operands.
    task automatic run_op(input bit wide, input op_e op, input int unsigned a,
                          input int unsigned b, input string tag, input int hold);
        obs_t o;
        exp_t e;
        int   lat = 0;
        o = sample(wide);
        while (o.ready !== 32'd1 && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
            o = sample(wide);
        end
        check({tag, "_in_ready"}, o.ready, 1);
        sb.push_back(model(wide ? W_W : W_N, op, a, b, tag));
        drive(wide, 1'b1, op, a, b);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        drive(wide, 1'b1, op_e'(4'($urandom_range(15, 0))), $urandom, $urandom);
        o = sample(wide);
        while (o.valid !== 32'd1 && lat < TIMEOUT) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            o = sample(wide);
        end
        e = sb.pop_front();
        check({e.tag, "_out_valid"}, o.valid, 1);
        check({e.tag, "_busy"},      o.ready, 0);
        check({e.tag, "_res"},       o.res,   e.res);
        check({e.tag, "_hi"},        o.hi,    e.hi);
        check({e.tag, "_carry"},     o.carry, e.carry);
        check({e.tag, "_err"},       o.err,   e.err);
        check({e.tag, "_latency"},   lat,     e.lat);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            o = sample(wide);
            check({e.tag, "_hold_valid"}, o.valid, 1);
            check({e.tag, "_hold_ready"}, o.ready, 0);
            check({e.tag, "_hold_res"},   o.res,   e.res);
            check({e.tag, "_hold_hi"},    o.hi,    e.hi);
        end
        drive(wide, 1'b0, OP_ADD, 0, 0);
        set_out_ready(wide, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_out_ready(wide, 1'b0);
        o = sample(wide);
        check({e.tag, "_release_valid"}, o.valid, 0);
        check({e.tag, "_release_ready"}, o.ready, 1);
        if (hold > 0) begin
            @(posedge clk);
            @(negedge clk);
            o = sample(wide);
            check({e.tag, "_ignored_cmd"}, o.valid, 0);
        end
    endtask

    initial begin
        obs_t o;
        rst = 1'b1;
        drive(1'b0, 1'b0, OP_ADD, 0, 0);
        drive(1'b1, 1'b0, OP_ADD, 0, 0);
        set_out_ready(1'b0, 1'b0);
        set_out_ready(1'b1, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_reset(1'b0, "reset4");
        check_idle_reset(1'b1, "reset8");
        rst = 1'b0;
        @(negedge clk);

        // WIDTH=4 directed
        run_op(1'b0, OP_ADD,  4,    3,   "add_4_3",   0);
        run_op(1'b0, OP_SUB,  3,    5,   "sub_3_5",   0);
        run_op(1'b0, OP_MUL,  7,    3,   "mul_7_3",   3);
        run_op(1'b0, OP_DIV,  6,    2,   "div_6_2",   0);
        run_op(1'b0, OP_DIV,  9,    0,   "div_9_0",   0);
        run_op(1'b0, OP_ADD,  4'hF, 1,   "add_carry", 0);
        run_op(1'b0, OP_NAND, 4'hA, 4'hC, "nand",     0);
        run_op(1'b0, OP_XNOR, 5,    9,   "xnor",      0);
        run_op(1'b0, OP_SHL,  1,    4,   "shl_over",  0);
        run_op(1'b0, OP_SHR,  4'hC, 2,   "shr_2",     0);
        run_op(1'b0, OP_GT,   5,    3,   "gt",        0);
        run_op(1'b0, OP_LT,   5,    3,   "lt",        0);
        run_op(1'b0, OP_INC,  4'hF, 7,   "inc4_wrap", 0);

        // Reset asserted during the second cycle of a MUL aborts it.
        drive(1'b0, 1'b1, OP_MUL, 7, 3);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, OP_ADD, 0, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_idle_reset(1'b0, "mul_abort");
        repeat (6) @(posedge clk);
        @(negedge clk);
        o = sample(1'b0);
        check("mul_abort_discarded", o.valid, 0);
        run_op(1'b0, OP_ADD, 2, 3, "add_after_rst", 0);

        // WIDTH=8 directed
        run_op(1'b1, OP_SHL, 8'h03, 2,     "shl8",     0);
        run_op(1'b1, OP_SHR, 8'hF0, 9,     "shr8_over", 0);
        run_op(1'b1, OP_EQ,  5,     5,     "eq8",      0);
        run_op(1'b1, OP_INC, 8'hFF, 8'h12, "inc8_wrap", 0);
        run_op(1'b1, OP_NOR, 8'h5A, 8'h0F, "nor8",     0);
        run_op(1'b1, OP_SUB, 8'h10, 8'h20, "sub8",     0);

        // Random MUL/DIV against the model
        for (int i = 0; i < 8; i++) begin
            run_op(1'b1, OP_MUL, $urandom_range(255, 0), $urandom_range(255, 0), "rnd8_mul", 0);
            run_op(1'b1, OP_DIV, $urandom_range(255, 0),
                   (i == 0) ? 0 : $urandom_range(255, 0), "rnd8_div", 0);
            run_op(1'b0, OP_MUL, $urandom_range(15, 0), $urandom_range(15, 0), "rnd4_mul", 0);
            run_op(1'b0, OP_DIV, $urandom_range(15, 0), $urandom_range(15, 1), "rnd4_div", 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand and result width in bits (legal 2..16).
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH)+1, iteration counter width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operands and op presented.
REQ-006 SHALL have port in_ready  output  1  block can accept a command.
REQ-007 SHALL have ports a, b  input  WIDTH each  operands A, B (unsigned).
REQ-008 SHALL have port op  input  4  opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 XOR, 7 NAND, 8 NOR, 9 XNOR, 10 SHL, 11 SHR, 12 GT, 13 LT, 14 EQ, 15 INC.
REQ-009 SHALL have port out_valid  output  1  result registers hold a completed result.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port result  output  WIDTH  primary result (low product half, quotient).
REQ-012 SHALL have port result_hi  output  WIDTH  high product half (MUL), remainder (DIV), else 0.
REQ-013 SHALL have port carry  output  1  ADD/INC carry-out, SUB borrow, else 0.
REQ-014 SHALL have port err  output  1  divide-by-zero or disabled-op flag.

Function
REQ-015 SHALL implement FSM states IDLE, MUL, DIV, DONE; in_ready = 1 only in IDLE.
REQ-016 SHALL accept a command on the edge where in_valid & in_ready; a, b, op captured into internal registers there.
REQ-017 Ops 0,1,4..15 SHALL go IDLE->DONE; out_valid rises one cycle after acceptance.
REQ-018 MUL SHALL be shift-add, one partial product per cycle, WIDTH cycles in MUL, then DONE; out_valid WIDTH+1 cycles after acceptance; {result_hi,result} = a*b exact.
REQ-019 DIV SHALL be restoring, one quotient bit per cycle, WIDTH cycles in DIV, then DONE; result = a/b, result_hi = a%b.
REQ-020 DIV with b==0 SHALL go IDLE->DONE in one cycle with result = all-ones, result_hi = a, err = 1.
REQ-021 SUB SHALL give result = (a-b) mod 2^WIDTH, carry = (a<b).
REQ-022 ADD SHALL give {carry,result} = a+b; INC SHALL give {carry,result} = a+1, b ignored.
REQ-023 SHL/SHR SHALL shift a logically by b; b >= WIDTH yields result 0.
REQ-024 GT/LT/EQ SHALL give result = 1 if true else 0 (zero-extended).
REQ-025 In DONE, out_valid = 1 and outputs SHALL hold stable until out_ready; DONE->IDLE on out_valid & out_ready.
REQ-026 in_valid while not in IDLE SHALL be ignored; operands changing mid-operation SHALL not affect the result.
REQ-027 All outputs SHALL be driven from registers; no combinational path from inputs to outputs except none (in_ready from state only).

Reset
REQ-028 rst SHALL force IDLE, in_ready = 1, out_valid = 0, result = 0, result_hi = 0, carry = 0, err = 0, counter = 0.
REQ-029 rst asserted mid-MUL/DIV or in DONE SHALL abort the operation and discard the result; rst has priority over all other inputs.

Configuration
REQ-030 Macro ALU_MULDIV_EN defined: MUL and DIV SHALL behave per REQ-018..020.
REQ-031 Macro ALU_MULDIV_EN undefined: MUL/DIV states and datapath SHALL be absent; op 2/3 SHALL complete in one cycle with result = 0, result_hi = 0, carry = 0, err = 1.

Verification
REQ-032 WIDTH=4, ADD a=4 b=3 -> one cycle later out_valid, result=7, carry=0; SUB a=3 b=5 -> result=4'b1110, carry=1.
REQ-033 WIDTH=4, MUL a=7 b=3 with ALU_MULDIV_EN -> out_valid 5 cycles after accept, result=4'h5, result_hi=4'h1; without macro -> result=0, err=1 after 1 cycle.
REQ-034 WIDTH=4, DIV a=6 b=2 -> result=3, result_hi=0 after 5 cycles; DIV a=9 b=0 -> result=4'hF, result_hi=9, err=1 after 1 cycle.
REQ-035 out_ready held low 3 cycles in DONE -> outputs stable, in_ready=0, second in_valid ignored; out_ready high -> IDLE next cycle.
REQ-036 rst pulsed during cycle 2 of MUL -> next cycle all outputs at reset values, in_ready=1; following ADD completes normally.
REQ-037 WIDTH=8 sweep: SHL a=8'h03 b=2 -> 8'h0C; SHR b=9 -> 0; EQ a=b=5 -> 1; INC a=8'hFF -> result=0, carry=1; random MUL/DIV vs reference model.
